eh2_lsu_halt_sync: RTL and testbench

Per-thread force-halt synchronizer and drain tracker for the LSU. It aligns `dec_tlu_force_halt` to bus-clock-enable edges, producing `dec_tlu_force_halt_bus`, which the LSU clock-domain block uses to keep the bus clocks running. It then watches the bus buffer and store buffer until they drain and reports halt completion back to the TLU. It sits directly upstream of the LSU clock-domain block, alongside the bus buffer.

---
 rtl/eh2_pkg.sv | 20 ++
 rtl/eh2_lsu_halt_sync_thr.sv | 110 +++++++++++
 rtl/eh2_lsu_halt_sync.sv | 45 ++++
 tb/tb_eh2_lsu_halt_sync.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eh2_pkg.sv
// eh2_pkg: shared configuration type and LSU halt-sync FSM encoding
//   eh2_param_t          core configuration (NUM_THREADS: 1 or 2)
//   EH2_PARAM_DEFAULT    default configuration, two threads
//   eh2_lsu_halt_state_e per-thread halt FSM state
package eh2_pkg;

    typedef struct packed {
        int unsigned NUM_THREADS;
    } eh2_param_t;

    localparam eh2_param_t EH2_PARAM_DEFAULT = '{NUM_THREADS: 32'd2};

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SYNC  = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } eh2_lsu_halt_state_e;

endpackage

// File: rtl/eh2_lsu_halt_sync_thr.sv
// eh2_lsu_halt_sync_thr: one thread's force-halt bus alignment and drain tracker
//   clk, rst_l           core clock, async active-low reset
//   i_force_halt         level force-halt request
//   i_bus_clk_en         strobe for cycles carrying a bus clock edge
//   i_bus_buffer_empty, i_stbuf_empty, i_bus_idle  drain status
//   o_halt_bus           bus-aligned force halt
//   o_done               drained (or timed out) under force halt, sticky until release
//   o_timeout            drain ended by timeout
// Optional drain timeout enabled by RV_LSU_HALT_TIMEOUT_EN.
module eh2_lsu_halt_sync_thr
    import eh2_pkg::*;
#(
    parameter int TIMEOUT_W = 8
) (
    input  logic clk,
    input  logic rst_l,
    input  logic i_force_halt,
    input  logic i_bus_clk_en,
    input  logic i_bus_buffer_empty,
    input  logic i_stbuf_empty,
    input  logic i_bus_idle,
    output logic o_halt_bus,
    output logic o_done,
    output logic o_timeout
);

    eh2_lsu_halt_state_e r_state, w_state_nxt;
    logic r_halt_bus, r_done, r_timeout;
    logic w_halt_bus_nxt, w_done_nxt, w_timeout_nxt;
    logic w_drained, w_release, w_to_hit;

    assign w_drained = i_bus_buffer_empty & i_stbuf_empty & i_bus_idle;
    assign w_release = ~i_force_halt & i_bus_clk_en;

`ifdef RV_LSU_HALT_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_cnt;

    assign w_to_hit = &r_cnt;

    // Held at zero outside DRAIN so every DRAIN entry starts a fresh count.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)
            r_cnt <= '0;
        else if (r_state != DRAIN)
            r_cnt <= '0;
        else if (i_bus_clk_en && !w_to_hit)
            r_cnt <= r_cnt + TIMEOUT_W'(1);
    end
`else
    // No counter: the drain can never time out (width is only referenced here).
    assign w_to_hit = (TIMEOUT_W < 0);
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_halt_bus_nxt = r_halt_bus;
        w_done_nxt     = r_done;
        w_timeout_nxt  = r_timeout;
        unique case (r_state)
            IDLE: w_state_nxt = i_force_halt ? SYNC : IDLE;
            SYNC: begin
                if (!i_force_halt)
                    w_state_nxt = IDLE;
                else if (i_bus_clk_en) begin
                    w_state_nxt    = DRAIN;
                    w_halt_bus_nxt = 1'b1;
                end
            end
            DRAIN: begin
                // Release beats drained, drained beats timeout.
                if (w_release) begin
                    w_state_nxt    = IDLE;
                    w_halt_bus_nxt = 1'b0;
                end else if (w_drained || w_to_hit) begin
                    w_state_nxt   = DONE;
                    w_done_nxt    = 1'b1;
                    w_timeout_nxt = ~w_drained;
                end
            end
            DONE: begin
                if (w_release) begin
                    w_state_nxt    = IDLE;
                    w_halt_bus_nxt = 1'b0;
                    w_done_nxt     = 1'b0;
                    w_timeout_nxt  = 1'b0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state    <= IDLE;
            r_halt_bus <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_halt_bus <= w_halt_bus_nxt;
            r_done     <= w_done_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign o_halt_bus = r_halt_bus;
    assign o_done     = r_done;
    assign o_timeout  = r_timeout;

endmodule

// File: rtl/eh2_lsu_halt_sync.sv
// eh2_lsu_halt_sync: per-thread force-halt bus synchronizer and LSU drain tracker
//   clk, rst_l                  core clock, async active-low reset
//   dec_tlu_force_halt[NT]      level force-halt request per thread
//   lsu_bus_clk_en              strobe for cycles carrying a bus clock edge
//   lsu_bus_buffer_empty_any[NT], lsu_stbuf_empty_any[NT], lsu_bus_idle_any[NT]
//   dec_tlu_force_halt_bus[NT]  bus-aligned force halt
//   lsu_force_halt_done[NT]     LSU drained under force halt
//   lsu_force_halt_timeout[NT]  drain ended by timeout
// Optional drain timeout enabled by RV_LSU_HALT_TIMEOUT_EN.
module eh2_lsu_halt_sync
    import eh2_pkg::*;
#(
    parameter eh2_param_t pt        = EH2_PARAM_DEFAULT,
    parameter int         TIMEOUT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_l,
    input  logic [pt.NUM_THREADS-1:0] dec_tlu_force_halt,
    input  logic                      lsu_bus_clk_en,
    input  logic [pt.NUM_THREADS-1:0] lsu_bus_buffer_empty_any,
    input  logic [pt.NUM_THREADS-1:0] lsu_stbuf_empty_any,
    input  logic [pt.NUM_THREADS-1:0] lsu_bus_idle_any,
    output logic [pt.NUM_THREADS-1:0] dec_tlu_force_halt_bus,
    output logic [pt.NUM_THREADS-1:0] lsu_force_halt_done,
    output logic [pt.NUM_THREADS-1:0] lsu_force_halt_timeout
);

    for (genvar i = 0; i < pt.NUM_THREADS; i++) begin : g_thr
        eh2_lsu_halt_sync_thr #(
            .TIMEOUT_W(TIMEOUT_W)
        ) u_thr (
            .clk               (clk),
            .rst_l             (rst_l),
            .i_force_halt      (dec_tlu_force_halt[i]),
            .i_bus_clk_en      (lsu_bus_clk_en),
            .i_bus_buffer_empty(lsu_bus_buffer_empty_any[i]),
            .i_stbuf_empty     (lsu_stbuf_empty_any[i]),
            .i_bus_idle        (lsu_bus_idle_any[i]),
            .o_halt_bus        (dec_tlu_force_halt_bus[i]),
            .o_done            (lsu_force_halt_done[i]),
            .o_timeout         (lsu_force_halt_timeout[i])
        );
    end

endmodule

// File: tb/tb_eh2_lsu_halt_sync.sv
// tb_eh2_lsu_halt_sync: self-checking bench for eh2_lsu_halt_sync against a behavioural model
module tb_eh2_lsu_halt_sync;

    localparam int TW   = 3;
    localparam int MAXC = (1 << TW) - 1;
`ifdef RV_LSU_HALT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_l;
    logic       en;
    logic [1:0] fh, bbe, sbe, idle;
    logic [1:0] hb, dn, to;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: m_pend = request seen while bus halt not yet raised
    logic [1:0] m_pend, m_hb, m_dn, m_to;
    int         m_cnt [2];

    always #5 clk = ~clk;

    eh2_lsu_halt_sync #(.TIMEOUT_W(TW)) dut (
        .clk                     (clk),
        .rst_l                   (rst_l),
        .dec_tlu_force_halt      (fh),
        .lsu_bus_clk_en          (en),
        .lsu_bus_buffer_empty_any(bbe),
        .lsu_stbuf_empty_any     (sbe),
        .lsu_bus_idle_any        (idle),
        .dec_tlu_force_halt_bus  (hb),
        .lsu_force_halt_done     (dn),
        .lsu_force_halt_timeout  (to)
    );

    function automatic void model_reset();
        m_pend = '0; m_hb = '0; m_dn = '0; m_to = '0;
        m_cnt[0] = 0; m_cnt[1] = 0;
    endfunction

    function automatic void model_step();
        if (!rst_l) begin
            model_reset();
            return;
        end
        for (int t = 0; t < 2; t++) begin
            if (!m_hb[t]) begin
                if (m_pend[t] && fh[t] && en) begin
                    m_hb[t] = 1'b1; m_pend[t] = 1'b0; m_cnt[t] = 0;
                end else
                    m_pend[t] = fh[t];
            end else if (!fh[t] && en) begin
                m_hb[t] = 1'b0; m_dn[t] = 1'b0; m_to[t] = 1'b0;
            end else if (!m_dn[t]) begin
                if (bbe[t] && sbe[t] && idle[t])
                    m_dn[t] = 1'b1;
                else if (TO_EN && m_cnt[t] == MAXC) begin
                    m_dn[t] = 1'b1; m_to[t] = 1'b1;
                end else if (en)
                    m_cnt[t]++;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic settle();
        fh = 2'b00; en = 1'b1; bbe = 2'b11; sbe = 2'b11; idle = 2'b11;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        #1 rst_l = 1'b0;
        #1;
        n_tests++;
        if ({to, dn, hb} !== 6'b0) begin
            n_fail++; $display("FAIL reset_async: got %b want %b", {to, dn, hb}, 6'b0);
        end
        fh = 2'b11; en = 1'b1; bbe = 2'b11; sbe = 2'b11; idle = 2'b11;
        tick(); tick();
        n_tests++;
        if ({to, dn, hb} !== 6'b0) begin
            n_fail++; $display("FAIL reset_hold: got %b want %b", {to, dn, hb}, 6'b0);
        end
        rst_l = 1'b1; fh = 2'b00;
        tick();
        n_tests++;
        if ({to, dn, hb} !== {m_to, m_dn, m_hb}) begin
            n_fail++; $display("FAIL reset_exit: got %b want %b", {to, dn, hb}, {m_to, m_dn, m_hb});
        end
    endtask

    task automatic test_continuous();
        settle();
        fh = 2'b01;
        for (int c = 1; c <= 5; c++) begin
            if (c == 4) fh = 2'b00;
            tick();
            n_tests++;
            if ({dn[0], hb[0]} !== {c == 3, c == 2 || c == 3} || {to, dn, hb} !== {m_to, m_dn, m_hb}) begin
                n_fail++; $display("FAIL continuous c=%0d: got %b want %b (t0 dn/hb %b%b)", c, {to, dn, hb}, {m_to, m_dn, m_hb}, c == 3, c == 2 || c == 3);
            end
        end
    endtask

    task automatic test_ratio4();
        settle();
        for (int k = 0; k < 30; k++) begin
            en = (k % 4 == 0);
            fh = {1'b0, k >= 1 && k <= 20};
            tick();
            n_tests++;
            if ({dn[0], hb[0]} !== {k + 1 >= 6 && k + 1 <= 24, k + 1 >= 5 && k + 1 <= 24} || {to, dn, hb} !== {m_to, m_dn, m_hb}) begin
                n_fail++; $display("FAIL ratio4 cyc=%0d: got %b want %b", k + 1, {to, dn, hb}, {m_to, m_dn, m_hb});
            end
        end
    endtask

    task automatic test_sync_abort();
        settle();
        for (int k = 0; k < 16; k++) begin
            en = (k % 4 == 0);
            fh = {1'b0, k == 1 || k == 2};
            tick();
            n_tests++;
            if (hb !== 2'b00 || {to, dn, hb} !== {m_to, m_dn, m_hb}) begin
                n_fail++; $display("FAIL sync_abort cyc=%0d: got %b want %b", k + 1, {to, dn, hb}, {m_to, m_dn, m_hb});
            end
        end
    endtask

    task automatic test_drain_release();
        settle();
        sbe = 2'b10; fh = 2'b01;
        tick(); tick();
        n_tests++;
        if ({dn[0], hb[0]} !== 2'b01) begin
            n_fail++; $display("FAIL drain_enter: got dn/hb %b want %b", {dn[0], hb[0]}, 2'b01);
        end
        sbe = 2'b11; fh = 2'b00;
        for (int c = 1; c <= 2; c++) begin
            tick();
            n_tests++;
            if ({to, dn, hb} !== 6'b0 || {to, dn, hb} !== {m_to, m_dn, m_hb}) begin
                n_fail++; $display("FAIL drain_release c=%0d: got %b want %b", c, {to, dn, hb}, 6'b0);
            end
        end
    endtask

    task automatic test_timeout();
        settle();
        sbe = 2'b10; fh = 2'b01;
        tick(); tick();
        for (int c = 1; c <= 12; c++) begin
            tick();
            n_tests++;
            if ({to[0], dn[0], hb[0]} !== ((TO_EN && c >= MAXC + 1) ? 3'b111 : 3'b001) || {to, dn, hb} !== {m_to, m_dn, m_hb}) begin
                n_fail++; $display("FAIL timeout c=%0d: got %b want %b", c, {to, dn, hb}, {m_to, m_dn, m_hb});
            end
        end
        fh = 2'b00;
        tick();
        n_tests++;
        if ({to, dn, hb} !== 6'b0) begin
            n_fail++; $display("FAIL timeout_release: got %b want %b", {to, dn, hb}, 6'b0);
        end
    endtask

    task automatic test_random();
        settle();
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 9) == 0) fh[0] = ~fh[0];
            if ($urandom_range(0, 9) == 0) fh[1] = ~fh[1];
            en   = 1'($urandom_range(0, 1));
            bbe  = {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0};
            sbe  = {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0};
            idle = {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0};
            if (k < 400) begin
                fh[1] = fh[0]; bbe[1] = bbe[0]; sbe[1] = sbe[0]; idle[1] = idle[0];
            end
            tick();
            n_tests++;
            if ({to, dn, hb} !== {m_to, m_dn, m_hb}) begin
                n_fail++; $display("FAIL random k=%0d: got %b want %b", k, {to, dn, hb}, {m_to, m_dn, m_hb});
            end
            if (k < 400) begin
                n_tests++;
                if ({to[1], dn[1], hb[1]} !== {to[0], dn[0], hb[0]}) begin
                    n_fail++; $display("FAIL thread_mirror k=%0d: t1 %b t0 %b", k, {to[1], dn[1], hb[1]}, {to[0], dn[0], hb[0]});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        settle();
        sbe = 2'b01; fh = 2'b10;
        repeat (3) tick();
        n_tests++;
        if ({to, dn, hb} !== 6'b000010) begin
            n_fail++; $display("FAIL mid_drain_t1: got %b want %b", {to, dn, hb}, 6'b000010);
        end
        #2 rst_l = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({to, dn, hb} !== 6'b0) begin
            n_fail++; $display("FAIL reset_mid: got %b want %b", {to, dn, hb}, 6'b0);
        end
        tick();
        rst_l = 1'b1; fh = 2'b00;
        tick();
        n_tests++;
        if ({to, dn, hb} !== {m_to, m_dn, m_hb}) begin
            n_fail++; $display("FAIL reset_mid_exit: got %b want %b", {to, dn, hb}, {m_to, m_dn, m_hb});
        end
    endtask

    initial begin
        rst_l = 1'b1; en = 1'b0; fh = '0; bbe = '0; sbe = '0; idle = '0;
        model_reset();
        test_reset();
        test_continuous();
        test_ratio4();
        test_sync_abort();
        test_drain_release();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
